// File: rtl/bnn_conv_multi.sv
// bnn_conv_multi: multi-kernel binary (XNOR/popcount) 3x3 convolution engine.
// Streams square bit-images (3..DATA_W wide) from the input SRAM, and applies NUM_K kernels with a
// runtime threshold. It writes one output word per kernel per output row. Images are processed
// back to back until a 0xFF header is read.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   dut_run                    start pulse (sampled in IDLE only)
//   dut_busy, dut_error        run in progress / invalid header seen
//   dut_sram_read_address      header/row read address; sram_dut_read_data returns 1 cycle later
//   dut_sram_write_*           output word write port
//   dut_wmem_read_address      weight memory address; wmem_dut_read_data returns 1 cycle later
module bnn_conv_multi #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NUM_K  = 2,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dut_run,
    output logic              dut_busy,
    output logic              dut_error,
    output logic [ADDR_W-1:0] dut_sram_read_address,
    input  logic [DATA_W-1:0] sram_dut_read_data,
    output logic [ADDR_W-1:0] dut_sram_write_address,
    output logic [DATA_W-1:0] dut_sram_write_data,
    output logic              dut_sram_write_enable,
    output logic [ADDR_W-1:0] dut_wmem_read_address,
    input  logic [DATA_W-1:0] wmem_dut_read_data
);

    typedef enum logic [2:0] {StIdle, StLoadW, StHdr, StFill, StCompute, StShift, StDone} state_e;

    localparam logic [3:0] KLast    = 4'(NUM_K);
    localparam logic [3:0] LoadLast = 4'(NUM_K + 1);
    localparam logic [7:0] MaxN     = 8'(DATA_W);

    state_e            r_state, w_state_next;
    logic [3:0]        r_cnt;        // cycles spent in the current state
    logic              r_busy, r_err, r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [ADDR_W-1:0] r_waddr, r_wptr, r_raddr, r_wmaddr;
    logic [3:0]        r_thr;
    logic [8:0]        r_kern [NUM_K];
    logic [DATA_W-1:0] r_win0, r_win1, r_win2;   // top, middle, bottom window rows
    logic [7:0]        r_n, r_row;

    logic [7:0]        w_hdr;
    logic              w_hdr_term, w_hdr_bad, w_last_row;
    logic [8:0]        w_kern;
    logic [DATA_W-1:0] w_result;
    logic              w_unused;

    assign w_hdr      = sram_dut_read_data[7:0];
    assign w_hdr_term = (w_hdr == 8'hFF);
    assign w_hdr_bad  = (w_hdr < 8'd3) || (w_hdr > MaxN);
    assign w_last_row = (r_row == r_n - 8'd3);
    assign w_unused   = ^wmem_dut_read_data[DATA_W-1:9];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= (w_state_next != r_state) ? 4'd0 : r_cnt + 4'd1;
        end
    end

    // Next-state logic; read data is valid in count 1 of a state after its address was set.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:    if (dut_run) w_state_next = StLoadW;
            StLoadW:   if (r_cnt == LoadLast) w_state_next = StHdr;
            StHdr: begin
                if (r_cnt == 4'd1) begin
                    w_state_next = (w_hdr_term || w_hdr_bad) ? StDone : StFill;
                end
            end
            StFill:    if (r_cnt == 4'd3) w_state_next = StCompute;
            StCompute: if (r_cnt == KLast) w_state_next = w_last_row ? StHdr : StShift;
            StShift:   if (r_cnt == 4'd1) w_state_next = StCompute;
            StDone:    w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    // Kernel for the write issued this cycle (k tracks the COMPUTE count)
    always_comb begin
        w_kern = '0;
        for (int k = 0; k < int'(NUM_K); k++) begin
            if (r_cnt == 4'(k)) w_kern = r_kern[k];
        end
    end

    // XNOR/popcount per output column; columns at or past N-2 are forced to 0
    always_comb begin
        logic [8:0] w_win9;
        logic [3:0] w_pop;
        w_result = '0;
        w_win9   = '0;
        w_pop    = '0;
        for (int c = 0; c < int'(DATA_W) - 2; c++) begin
            w_win9 = {r_win2[c +: 3], r_win1[c +: 3], r_win0[c +: 3]};
            w_pop  = '0;
            for (int j = 0; j < 9; j++) begin
                w_pop = w_pop + {3'b000, ~(w_win9[j] ^ w_kern[j])};
            end
            if ((w_pop >= r_thr) && (c + 2 < int'(r_n))) w_result[c] = 1'b1;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
            r_we     <= 1'b0;
            r_wdata  <= '0;
            r_waddr  <= '0;
            r_wptr   <= '0;
            r_raddr  <= '0;
            r_wmaddr <= '0;
            r_thr    <= '0;
            r_win0   <= '0;
            r_win1   <= '0;
            r_win2   <= '0;
            r_n      <= '0;
            r_row    <= '0;
            for (int k = 0; k < int'(NUM_K); k++) r_kern[k] <= '0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (dut_run) begin
                        r_busy   <= 1'b1;
                        r_err    <= 1'b0;
                        r_wmaddr <= '0;
                        r_raddr  <= '0;
                        r_wptr   <= '0;
                    end
                end
                StLoadW: begin
                    r_wmaddr <= r_wmaddr + 1'b1;
                    if (r_cnt == 4'd1) r_thr <= wmem_dut_read_data[3:0];
                    for (int k = 0; k < int'(NUM_K); k++) begin
                        if (r_cnt == 4'(k + 2)) r_kern[k] <= wmem_dut_read_data[8:0];
                    end
                end
                StHdr: begin
                    if (r_cnt == 4'd1) begin
                        r_n   <= w_hdr;
                        r_row <= '0;
                        if (w_hdr_term) begin
                            r_busy <= 1'b0;
                        end else if (w_hdr_bad) begin
                            r_busy <= 1'b0;
                            r_err  <= 1'b1;
                        end else begin
                            r_raddr <= r_raddr + 1'b1;
                        end
                    end
                end
                StFill: begin
                    // Address runs one ahead of the data; it stops on the third row.
                    if (r_cnt < 4'd2) r_raddr <= r_raddr + 1'b1;
                    if (r_cnt == 4'd1) r_win0 <= sram_dut_read_data;
                    if (r_cnt == 4'd2) r_win1 <= sram_dut_read_data;
                    if (r_cnt == 4'd3) r_win2 <= sram_dut_read_data;
                end
                StCompute: begin
                    if (r_cnt < KLast) begin
                        r_we    <= 1'b1;
                        r_wdata <= w_result;
                        r_waddr <= r_wptr;
                        r_wptr  <= r_wptr + 1'b1;
                    end else begin
                        // Next row, or the next header after the last row
                        r_raddr <= r_raddr + 1'b1;
                        if (!w_last_row) r_row <= r_row + 8'd1;
                    end
                end
                StShift: begin
                    if (r_cnt == 4'd1) begin
                        r_win0 <= r_win1;
                        r_win1 <= r_win2;
                        r_win2 <= sram_dut_read_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dut_busy               = r_busy;
    assign dut_error              = r_err;
    assign dut_sram_read_address  = r_raddr;
    assign dut_sram_write_address = r_waddr;
    assign dut_sram_write_data    = r_wdata;
    assign dut_sram_write_enable  = r_we;
    assign dut_wmem_read_address  = r_wmaddr;

endmodule
